// File: rtl/pattern_detector.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// a qualified input strobe and a saturating match counter.
module pattern_detector #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   fill,
  output logic [1:0]         state,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StArmed  = 2'b01,
    StDetect = 2'b10
  } state_e;

  state_e             state_q;
  logic [MAX_LEN-1:0] history_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill_q;
  logic               overlap_q;
  logic               match_q;
  logic [CNT_W-1:0]   count_q;
  logic               err_q;

  logic [MAX_LEN-1:0] history_nxt;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_nxt;
  logic               full_nxt;
  logic               hit;
  logic               cfg_bad;

  // Match is judged on the post-shift history so the pulse lines up with the
  // edge that accepts the final bit.
  always_comb begin
    history_nxt = {history_q[MAX_LEN-2:0], in_bit};
    fill_nxt    = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
    len_mask    = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    full_nxt = (fill_nxt == len_q);
    hit      = full_nxt && ((history_nxt & len_mask) == (pattern_q & len_mask));
    cfg_bad  = (cfg_len == '0) || (32'(cfg_len) > MAX_LEN);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= StIdle;
      history_q <= '0;
      pattern_q <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      overlap_q <= 1'b0;
      match_q   <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      match_q <= 1'b0;
      if (cfg_load) begin
        if (cfg_bad) begin
          err_q   <= 1'b1;
          state_q <= StIdle;
        end else begin
          pattern_q <= cfg_pattern;
          len_q     <= cfg_len;
          overlap_q <= cfg_overlap;
          err_q     <= 1'b0;
          history_q <= '0;
          fill_q    <= '0;
          count_q   <= '0;
          state_q   <= StArmed;
        end
      end else begin
        case (state_q)
          StIdle: ;
          StArmed, StDetect: begin
            if (in_valid) begin
              history_q <= history_nxt;
              if (hit) begin
                match_q <= 1'b1;
                if (count_q != '1) count_q <= count_q + CNT_W'(1);
              end
              // Non-overlap restarts the fill so the next match needs len fresh bits.
              if (hit && !overlap_q) begin
                fill_q  <= '0;
                state_q <= StArmed;
              end else begin
                fill_q <= fill_nxt;
                if (full_nxt) state_q <= StDetect;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign match       = match_q;
  assign match_count = count_q;
  assign fill        = fill_q;
  assign state       = state_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_pattern_detector.sv
// Directed and random stimulus for pattern_detector, checked each cycle against
// a queue-based model of the detection rules.
module tb_pattern_detector;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LEN_W   = 4;
  localparam int          CNT_MAX = 255;

  logic               clock;
  logic               resetn;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               in_bit;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic [LEN_W-1:0]   fill;
  logic [1:0]         state;
  logic               cfg_err;

  pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .match       (match),
    .match_count (match_count),
    .fill        (fill),
    .state       (state),
    .cfg_err     (cfg_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: accepted bits since the last valid load, plus a count of
  // samples gathered toward the current match window.
  bit       m_active;
  int       m_len;
  bit [7:0] m_pat;
  bit       m_ovl;
  bit       m_hist[$];
  int       m_fresh;
  int       m_cnt;
  bit       m_err;
  bit       m_match;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rn, input bit ld, input bit [7:0] pat, input int ln,
                       input bit ovl, input bit v, input bit b);
    bit ok;
    m_match = 1'b0;
    if (!rn) begin
      m_active = 0; m_len = 0; m_pat = 0; m_ovl = 0; m_hist.delete();
      m_fresh = 0; m_cnt = 0; m_err = 0;
    end else if (ld) begin
      if (ln == 0 || ln > int'(MAX_LEN)) begin
        m_err = 1; m_active = 0;
      end else begin
        m_active = 1; m_len = ln; m_pat = pat; m_ovl = ovl; m_err = 0;
        m_hist.delete(); m_fresh = 0; m_cnt = 0;
      end
    end else if (v && m_active) begin
      m_hist.push_back(b);
      if (m_hist.size() > int'(MAX_LEN)) void'(m_hist.pop_front());
      m_fresh++;
      if (m_fresh >= m_len) begin
        ok = 1;
        for (int k = 0; k < m_len; k++)
          if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) ok = 0;
        if (ok) begin
          m_match = 1;
          if (m_cnt < CNT_MAX) m_cnt++;
          if (!m_ovl) m_fresh = 0;
        end
      end
    end
  endtask

  task automatic step(input bit rn, input bit ld, input bit [7:0] pat, input int ln,
                      input bit ovl, input bit v, input bit b);
    int efill;
    int estate;
    resetn = rn; cfg_load = ld; cfg_pattern = pat; cfg_len = LEN_W'(ln);
    cfg_overlap = ovl; in_valid = v; in_bit = b;
    model(rn, ld, pat, ln, ovl, v, b);
    @(posedge clock);
    #1;
    efill  = (m_fresh > m_len) ? m_len : m_fresh;
    estate = !m_active ? 0 : ((m_fresh >= m_len) ? 2 : 1);
    chk("match", 32'(match), 32'(m_match));
    chk("match_count", 32'(match_count), 32'(m_cnt));
    chk("fill", 32'(fill), 32'(efill));
    chk("state", 32'(state), 32'(estate));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic feed(input bit b);
    step(1, 0, 0, 0, 0, 1, b);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, $urandom_range(0, 1));
  endtask

  task automatic load(input bit [7:0] pat, input int ln, input bit ovl);
    step(1, 1, pat, ln, ovl, 1, 1);
  endtask

  bit [6:0] s7;
  int       r;

  initial begin
    s7 = 7'b1101101;
    step(0, 0, 0, 0, 0, 0, 0);
    chk("reset_state", 32'(state), 32'd0);
    gap(2);
    feed(1);
    chk("idle_ignores", 32'(fill), 32'd0);

    // Overlapping 1101 over 1101101.
    load(8'b1101, 4, 1);
    for (int i = 6; i >= 0; i--) feed(s7[i]);
    chk("t1_count", 32'(match_count), 32'd2);

    // Same stream, non-overlapping.
    load(8'b1101, 4, 0);
    for (int i = 6; i >= 0; i--) feed(s7[i]);
    chk("t2_count", 32'(match_count), 32'd1);
    chk("t2_fill", 32'(fill), 32'd3);

    // Gaps of in_valid low between bits.
    load(8'b1101, 4, 1);
    feed(1); gap(3); feed(1); gap(3); feed(0); gap(3); feed(1);
    chk("t3_match", 32'(match), 32'd1);
    gap(3);
    chk("t3_count", 32'(match_count), 32'd1);

    // len=1 back-to-back until the counter saturates.
    load(8'b1, 1, 1);
    for (int i = 0; i < CNT_MAX + 5; i++) feed(1);
    chk("t4_sat", 32'(match_count), 32'(CNT_MAX));
    chk("t4_match", 32'(match), 32'd1);

    // Rejected load in DETECT, then a valid len=3 load.
    load(8'b101, 3, 1);
    feed(1); feed(0); feed(1);
    load(8'b0, 0, 1);
    chk("t5_err", 32'(cfg_err), 32'd1);
    chk("t5_idle", 32'(state), 32'd0);
    load(8'b011, 3, 0);
    chk("t5_ok", 32'(cfg_err), 32'd0);
    chk("t5_armed", 32'(state), 32'd1);
    load(8'b011, 9, 0);
    chk("t5_too_long", 32'(cfg_err), 32'd1);

    // Reset mid-pattern: later bits must not match.
    load(8'b1101, 4, 1);
    feed(1); feed(1); feed(0);
    step(0, 0, 0, 0, 0, 1, 1);
    feed(1); feed(1);
    chk("t6_idle", 32'(state), 32'd0);
    chk("t6_nomatch", 32'(match_count), 32'd0);

    // Random traffic with occasional loads (some invalid) and resets.
    load(8'($urandom), $urandom_range(1, 4), $urandom_range(0, 1));
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 2) step(0, 0, 0, 0, 0, 1, 1);
      else if (r < 10) load(8'($urandom), $urandom_range(0, 9), $urandom_range(0, 1));
      else if (r < 14) step(1, 0, 8'($urandom), $urandom_range(0, 9), 1, 1, 1);
      else if (r < 150) feed($urandom_range(0, 1));
      else gap(1);
      if (!m_active && $urandom_range(0, 3) == 0)
        load(8'($urandom), $urandom_range(1, 3), $urandom_range(0, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
